// File: rtl/argo_fifo_reader.sv
// rtl/argo_fifo_reader.sv - pulls words from an argo_fifo into a 2-entry skid buffer for a ready/valid consumer
module argo_fifo_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  word_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    occ_t                  occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;

    logic       pop;
    logic       push;
    logic [2:0] level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    always_comb begin
        occ_d = occ_q;
        case (occ_q)
            EMPTY: if (push) occ_d = ONE;
            ONE: begin
                if (push && !pop)      occ_d = TWO;
                else if (!push && pop) occ_d = EMPTY;
            end
            TWO:     if (pop && !push) occ_d = ONE;
            default: occ_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (occ_q != EMPTY);
        pop       = out_valid && out_ready;
        push      = inflight_q;
        // Count the word already in flight so the buffer can never overflow.
        level      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en = !rst && en && !fifo_empty && (level < 3'd2);
        out_data   = out_valid ? head_q : '0;
        word_count = word_count_q;
    end

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        inflight_d   = fifo_rd_en;
        word_count_d = pop ? word_count_q + CNT_WIDTH'(1) : word_count_q;
        case (occ_q)
            EMPTY: if (push) head_d = fifo_rd_data;
            ONE: begin
                if (push && pop) head_d = fifo_rd_data;
                else if (push)   tail_d = fifo_rd_data;
            end
            TWO: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) tail_d = fifo_rd_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q   <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            word_count_q <= '0;
        end else begin
            inflight_q   <= inflight_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            word_count_q <= word_count_d;
        end
    end

endmodule
